// File: rtl/miriscv_bus_pkg.sv
// Shared types and default address map for the miriscv data-side interconnect.
// Slave 0 is the RAM window at the bottom of memory; slave 1 is the MMIO window.
package miriscv_bus_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RESP = 2'd1,
        ERR_RESP  = 2'd2
    } bus_state_e;

    localparam logic [31:0] RAM_BASE      = 32'h0000_0000;
    localparam logic [31:0] RAM_MASK      = 32'hFFFF_FF00;
    localparam logic [31:0] MMIO_BASE     = 32'h8000_0000;
    localparam logic [31:0] MMIO_MASK     = 32'hFFFF_F000;

    // Read data returned with an error response.
    localparam logic [31:0] BUS_ERR_RDATA = 32'h0000_0000;

endpackage

// File: rtl/miriscv_addr_decoder.sv
// Address decoder: per-slave base/mask match, lowest index wins on overlap.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the decoder only classifies the address.
module miriscv_addr_decoder
    import miriscv_bus_pkg::*;
#(
    parameter int                         N_SLAVES = 2,
    parameter int                         ADDR_W   = 32,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLV_BASE = {MMIO_BASE, RAM_BASE},
    parameter logic [N_SLAVES*ADDR_W-1:0] SLV_MASK = {MMIO_MASK, RAM_MASK},
    parameter int                         IDX_W    = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1
) (
    input  logic [ADDR_W-1:0]   addr_i,
    output logic [N_SLAVES-1:0] hit_o,
    output logic [IDX_W-1:0]    idx_o,
    output logic                miss_o
);

    logic [N_SLAVES-1:0] raw_hit;

    always_comb begin
        raw_hit = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            raw_hit[k] = ((addr_i & SLV_MASK[k*ADDR_W +: ADDR_W]) == SLV_BASE[k*ADDR_W +: ADDR_W]);
        end
    end

    // Scan from the top down so the lowest matching slave overwrites the rest.
    always_comb begin
        hit_o = '0;
        idx_o = '0;
        for (int k = N_SLAVES - 1; k >= 0; k--) begin
            if (raw_hit[k]) begin
                hit_o    = '0;
                hit_o[k] = 1'b1;
                idx_o    = IDX_W'(k);
            end
        end
    end

    assign miss_o = ~|raw_hit;

endmodule

// File: rtl/miriscv_data_bus.sv
// Data-side interconnect: core load/store port to N slaves, one outstanding transaction.
// Latency: grant same cycle as request; response >=1 cycle after grant, miss error next cycle.
// Backpressure: slave grant passes straight to the master; master holds request until granted.
module miriscv_data_bus
    import miriscv_bus_pkg::*;
#(
    parameter int                         N_SLAVES = 2,
    parameter int                         ADDR_W   = 32,
    parameter int                         DATA_W   = 32,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLV_BASE = {MMIO_BASE, RAM_BASE},
    parameter logic [N_SLAVES*ADDR_W-1:0] SLV_MASK = {MMIO_MASK, RAM_MASK},
    parameter int                         TIMEOUT  = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,

    input  logic                       m_req_i,
    input  logic                       m_we_i,
    input  logic [DATA_W/8-1:0]        m_be_i,
    input  logic [ADDR_W-1:0]          m_addr_i,
    input  logic [DATA_W-1:0]          m_wdata_i,
    output logic                       m_gnt_o,
    output logic                       m_rvalid_o,
    output logic [DATA_W-1:0]          m_rdata_o,
    output logic                       m_err_o,

    output logic [N_SLAVES-1:0]        s_req_o,
    output logic                       s_we_o,
    output logic [DATA_W/8-1:0]        s_be_o,
    output logic [ADDR_W-1:0]          s_addr_o,
    output logic [DATA_W-1:0]          s_wdata_o,
    input  logic [N_SLAVES-1:0]        s_gnt_i,
    input  logic [N_SLAVES-1:0]        s_rvalid_i,
    input  logic [N_SLAVES*DATA_W-1:0] s_rdata_i
);

    localparam int              IDX_W    = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int              TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    bus_state_e          state_q, state_d;
    logic [IDX_W-1:0]    sel_q, sel_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;

    logic [N_SLAVES-1:0] dec_hit;
    logic [IDX_W-1:0]    dec_idx;
    logic                dec_miss;

    logic [N_SLAVES-1:0] s_req;
    logic                gnt;
    logic                rvalid;
    logic                err;
    logic [DATA_W-1:0]   rdata;

    miriscv_addr_decoder #(
        .N_SLAVES (N_SLAVES),
        .ADDR_W   (ADDR_W),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK),
        .IDX_W    (IDX_W)
    ) u_addr_decoder (
        .addr_i (m_addr_i),
        .hit_o  (dec_hit),
        .idx_o  (dec_idx),
        .miss_o (dec_miss)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        tmo_cnt_d = tmo_cnt_q;
        s_req     = '0;
        gnt       = 1'b0;
        rvalid    = 1'b0;
        err       = 1'b0;
        rdata     = '0;

        unique case (state_q)
            IDLE: begin
                if (m_req_i) begin
                    if (dec_miss) begin
                        // Unmapped: accept immediately so the error can come back next cycle.
                        gnt     = 1'b1;
                        state_d = ERR_RESP;
                    end else begin
                        s_req = dec_hit;
                        gnt   = s_gnt_i[dec_idx];
                        if (gnt) begin
                            sel_d     = dec_idx;
                            tmo_cnt_d = '0;
                            state_d   = WAIT_RESP;
                        end
                    end
                end
            end
            WAIT_RESP: begin
                if (s_rvalid_i[sel_q]) begin
                    rvalid  = 1'b1;
                    rdata   = s_rdata_i[int'(sel_q)*DATA_W +: DATA_W];
                    state_d = IDLE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    tmo_cnt_d = '0;
                    state_d   = ERR_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            ERR_RESP: begin
                rvalid  = 1'b1;
                err     = 1'b1;
                rdata   = DATA_W'(BUS_ERR_RDATA);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    // Everything is forced quiet while reset is held so a pending response cannot leak out.
    assign m_gnt_o    = gnt & ~rst_i;
    assign m_rvalid_o = rvalid & ~rst_i;
    assign m_err_o    = err & ~rst_i;
    assign m_rdata_o  = rst_i ? '0 : rdata;
    assign s_req_o    = rst_i ? '0 : s_req;
    assign s_we_o     = m_we_i & ~rst_i;
    assign s_be_o     = rst_i ? '0 : m_be_i;
    assign s_addr_o   = rst_i ? '0 : m_addr_i;
    assign s_wdata_o  = rst_i ? '0 : m_wdata_i;

endmodule
